// File: rtl/dmem_mmio_bridge.sv
// Memory-stage slave: data RAM, LED register, UART TX (FIFO + 8N1 serializer)
// and a free-running cycle counter behind a word-aligned address decoder.
module dmem_mmio_bridge #(
  parameter int unsigned RAM_WORDS    = 64,
  parameter int unsigned LED_W        = 8,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      M_ALUResult,
  input  logic             M_MemWrite,
  input  logic [31:0]      M_WriteData,
  output logic [31:0]      M_ReadDataW,
  output logic [LED_W-1:0] led,
  output logic             uart_tx
);

  localparam int unsigned AW = $clog2(RAM_WORDS);
  localparam int unsigned FW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [31:0]      r_ram [RAM_WORDS];
  logic [LED_W-1:0] r_led;
  logic [31:0]      r_cnt;
  logic [7:0]       r_fifo [FIFO_DEPTH];
  logic [FW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [FW:0]      r_count;
  logic             r_ovf;
  state_t           r_state, w_state_next;
  logic [BW-1:0]    r_baud, w_baud_next;
  logic [2:0]       r_bit_idx, w_bit_next;
  logic [7:0]       r_shift, w_shift_next;
  logic             r_tx, w_tx_next;

  logic [29:0]   w_word;
  logic [AW-1:0] w_ram_idx;
  logic          w_sel_ram, w_sel_led, w_sel_uart, w_sel_cnt;
  logic          w_full, w_empty, w_busy, w_push_req, w_push, w_pop, w_bit_end;
  logic          w_unused;

  assign w_word     = M_ALUResult[31:2];
  assign w_ram_idx  = M_ALUResult[AW+1:2];
  assign w_sel_ram  = (M_ALUResult[31:AW+2] == '0);
  assign w_sel_led  = (w_word == 30'h0400_0000);
  assign w_sel_uart = (w_word == 30'h0400_0001);
  assign w_sel_cnt  = (w_word == 30'h0400_0002);
  assign w_unused   = ^M_ALUResult[1:0];

  assign w_full     = (r_count == (FW+1)'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_busy     = (r_state != S_IDLE);
  assign w_push_req = M_MemWrite && w_sel_uart;
  assign w_push     = w_push_req && !w_full;
  assign w_bit_end  = (r_baud == BW'(CLKS_PER_BIT - 1));

  // RAM storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (M_MemWrite && w_sel_ram) r_ram[w_ram_idx] <= M_WriteData;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= M_WriteData[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led    <= '0;
      r_cnt    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (M_MemWrite && w_sel_led) r_led <= M_WriteData[LED_W-1:0];
      r_cnt <= (M_MemWrite && w_sel_cnt) ? 32'h0 : r_cnt + 32'h1;
      if (w_push) r_wr_ptr <= r_wr_ptr + FW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + FW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (FW+1)'(1);
        2'b01:   r_count <= r_count - (FW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_push_req && w_full) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_baud    <= w_baud_next;
      r_bit_idx <= w_bit_next;
      r_shift   <= w_shift_next;
      r_tx      <= w_tx_next;
    end
  end

  // TX next state; uart_tx is registered from the next-state value so it
  // changes on the same edge as the state
  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud;
    w_bit_next   = r_bit_idx;
    w_shift_next = r_shift;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_shift_next = r_fifo[r_rd_ptr];
          w_baud_next  = '0;
          w_bit_next   = '0;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_baud_next  = '0;
          w_state_next = S_DATA;
        end else begin
          w_baud_next = r_baud + BW'(1);
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_baud_next  = '0;
          w_shift_next = {1'b0, r_shift[7:1]};
          w_bit_next   = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_state_next = S_STOP;
        end else begin
          w_baud_next = r_baud + BW'(1);
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_baud_next  = '0;
          w_state_next = S_IDLE;
        end else begin
          w_baud_next = r_baud + BW'(1);
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    case (w_state_next)
      S_START: w_tx_next = 1'b0;
      S_DATA:  w_tx_next = w_shift_next[0];
      default: w_tx_next = 1'b1;
    endcase
  end

  always_comb begin
    M_ReadDataW = 32'h0;
    if (w_sel_ram)       M_ReadDataW = r_ram[w_ram_idx];
    else if (w_sel_led)  M_ReadDataW = 32'(r_led);
    else if (w_sel_uart) M_ReadDataW = {28'h0, r_ovf, w_busy, w_empty, w_full};
    else if (w_sel_cnt)  M_ReadDataW = r_cnt;
  end

  assign led     = r_led;
  assign uart_tx = r_tx;

endmodule
